// File: rtl/uart_rx_if.sv
// Serial-receive bundle: the line into the receiver and the word/strobe out of it.
// The slave side is the receiver; the master side drives the line and consumes the words.
interface uart_rx_if #(
  parameter int WIDTH_WORD = 8
);
  logic                  i_bit_rx;
  logic                  o_rx_done;
  logic [WIDTH_WORD-1:0] o_data_out;

  modport master (output i_bit_rx, input  o_rx_done, input  o_data_out);
  modport slave  (input  i_bit_rx, output o_rx_done, output o_data_out);
endinterface

// File: rtl/uart_rx.sv
// UART receiver clocked by the 16x oversampling tick: start-bit qualify at mid-bit,
// LSB-first data, CANT_BIT_STOP stop bits, one-cycle strobe on a well-framed word.
module uart_rx #(
  parameter int WIDTH_WORD    = 8,
  parameter int CANT_BIT_STOP = 2
) (
  input  logic     i_rate,
  input  logic     i_reset,
  uart_rx_if.slave rx
);

  localparam int MAXB = (WIDTH_WORD > CANT_BIT_STOP) ? WIDTH_WORD : CANT_BIT_STOP;
  localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;

  localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH_WORD - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(CANT_BIT_STOP - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]            r_state;
  logic [3:0]            r_tick;
  logic [BW-1:0]         r_bit;
  logic [WIDTH_WORD-1:0] r_shift;
  logic                  r_ok;
  logic                  r_done;
  logic [WIDTH_WORD-1:0] r_data;

  logic w_mid;
  assign w_mid = (r_tick == 4'd15);

  always_ff @(posedge i_rate or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ok    <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!rx.i_bit_rx) begin
            r_state <= S_START;
            r_tick  <= '0;
          end
        end
        S_START: begin
          // Qualify the start bit at its midpoint; a high line here was a glitch.
          if (r_tick == 4'd7) begin
            if (!rx.i_bit_rx) begin
              r_state <= S_DATA;
              r_tick  <= '0;
              r_bit   <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_tick <= r_tick + 4'd1;
          end
        end
        S_DATA: begin
          if (w_mid) begin
            r_tick  <= '0;
            r_shift <= {rx.i_bit_rx, r_shift[WIDTH_WORD-1:1]};
            if (r_bit == LAST_DATA) begin
              r_state <= S_STOP;
              r_bit   <= '0;
              r_ok    <= 1'b1;
            end else begin
              r_bit <= r_bit + BIT_ONE;
            end
          end else begin
            r_tick <= r_tick + 4'd1;
          end
        end
        S_STOP: begin
          if (w_mid) begin
            r_tick <= '0;
            // Leave at the last stop-bit midpoint so a back-to-back start is not missed.
            if (r_bit == LAST_STOP) begin
              r_state <= S_IDLE;
              r_bit   <= '0;
              if (r_ok && rx.i_bit_rx) begin
                r_data <= r_shift;
                r_done <= 1'b1;
              end
            end else begin
              r_bit <= r_bit + BIT_ONE;
              r_ok  <= r_ok & rx.i_bit_rx;
            end
          end else begin
            r_tick <= r_tick + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx.o_rx_done  = r_done;
  assign rx.o_data_out = r_data;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 5 ns tick, 80 ns bits, hand-computed words and latency.
`timescale 1ns/1ps
module tb_uart_rx;

  logic i_rate;
  logic i_reset;

  uart_rx_if #(.WIDTH_WORD(8)) u_if ();

  uart_rx #(.WIDTH_WORD(8), .CANT_BIT_STOP(2)) u_dut (
    .i_rate  (i_rate),
    .i_reset (i_reset),
    .rx      (u_if)
  );

  initial i_rate = 1'b0;
  always #2.5 i_rate = ~i_rate;

  int n_tests = 0;
  int n_fail  = 0;

  int       cyc = 0;
  int       pulses = 0;
  int       pulse_cyc = 0;
  logic [7:0] words [$];

  always @(posedge i_rate) cyc <= cyc + 1;

  // Sample away from the active edge; a two-cycle strobe counts as two pulses.
  always @(negedge i_rate) begin
    if (u_if.o_rx_done === 1'b1) begin
      pulses    <= pulses + 1;
      pulse_cyc <= cyc;
      words.push_back(u_if.o_data_out);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    u_if.i_bit_rx = b;
    repeat (n) @(negedge i_rate);
  endtask

  int start_cyc;

  task automatic send_frame(input logic [7:0] d, input logic stop2);
    u_if.i_bit_rx = 1'b0;
    start_cyc = cyc;
    repeat (16) @(negedge i_rate);
    for (int i = 0; i < 8; i++) hold(d[i], 16);
    hold(1'b1, 16);
    hold(stop2, 16);
  endtask

  int p0;
  logic [7:0] w0, w1;

  initial begin
    u_if.i_bit_rx = 1'b1;
    i_reset = 1'b0;
    #10;
    i_reset = 1'b1;
    hold(1'b1, 8);
    chk("reset_done", 32'(u_if.o_rx_done), 32'h0);
    chk("reset_data", 32'(u_if.o_data_out), 32'h00);

    // Frame 0x69; start seen on the next edge, strobe 168 edges after that.
    send_frame(8'h69, 1'b1);
    hold(1'b1, 32);
    chk("f69_pulses", 32'(pulses), 32'd1);
    chk("f69_data", 32'(u_if.o_data_out), 32'h69);
    chk("f69_latency", 32'(pulse_cyc - start_cyc), 32'd169);

    send_frame(8'h69, 1'b0);
    hold(1'b1, 32);
    chk("ferr_pulses", 32'(pulses), 32'd1);
    chk("ferr_data", 32'(u_if.o_data_out), 32'h69);

    hold(1'b0, 4);
    hold(1'b1, 40);
    chk("glitch_pulses", 32'(pulses), 32'd1);
    chk("glitch_data", 32'(u_if.o_data_out), 32'h69);

    // Reset partway through data bit 1.
    hold(1'b0, 16);
    hold(1'b1, 24);
    i_reset = 1'b0;
    #1;
    chk("rst_mid_done", 32'(u_if.o_rx_done), 32'h0);
    chk("rst_mid_data", 32'(u_if.o_data_out), 32'h00);
    hold(1'b1, 3);
    i_reset = 1'b1;
    hold(1'b1, 20);
    send_frame(8'hA5, 1'b1);
    hold(1'b1, 32);
    chk("fa5_pulses", 32'(pulses), 32'd2);
    chk("fa5_data", 32'(u_if.o_data_out), 32'hA5);

    p0 = pulses;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    hold(1'b1, 32);
    chk("b2b_pulses", 32'(pulses - p0), 32'd2);
    w0 = (words.size() >= 4) ? words[2] : 8'hxx;
    w1 = (words.size() >= 4) ? words[3] : 8'hxx;
    chk("b2b_word0", 32'(w0), 32'h3C);
    chk("b2b_word1", 32'(w1), 32'hC3);
    chk("b2b_hold", 32'(u_if.o_data_out), 32'hC3);

    // Stuck-low line: framing errors only, then clean up with reset.
    p0 = pulses;
    hold(1'b0, 600);
    chk("stuck_pulses", 32'(pulses - p0), 32'd0);
    chk("stuck_data", 32'(u_if.o_data_out), 32'hC3);
    i_reset = 1'b0;
    hold(1'b1, 4);
    i_reset = 1'b1;
    hold(1'b1, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
